lfsr_mole_sel: RTL and testbench
================================

Name: lfsr_mole_sel

Overview:
Parametrised LFSR-based random target selector for the whack-a-mole game. On each request it searches the LFSR sequence for an index that is below NUM_MOLES and differs from the previous pick, then delivers a one-hot mole vector with a one-cycle valid pulse. An optional free-running step mode lets player timing add entropy. It sits between the game-control FSM and the mole LED/score logic.

Parameters:
WIDTH, 8, LFSR state width (min 3)
TAPS, 8'hB8, Galois feedback mask, WIDTH bits; the default is maximal-length (period 255)
NUM_MOLES, 5, number of targets (2..2**WIDTH)
MAX_TRIES, 16, search cycles allowed before fallback (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
seed_load  in  1  load seed into LFSR this cycle
seed  in  WIDTH  seed value; a value of 0 is replaced by all-ones
step_en  in  1  free-run: step LFSR every cycle while IDLE
req  in  1  request a new mole; sampled only in IDLE
busy  out  1  high while searching
mole_valid  out  1  one-cycle pulse when mole/mole_idx update
mole_idx  out  IDX_W  selected index, IDX_W = max(1, clog2(NUM_MOLES))
mole  out  NUM_MOLES  one-hot of mole_idx, held until the next result

Behaviour:
- Reset (async): state = all-ones; FSM = IDLE; busy = 0; mole_valid = 0; mole_idx = 0; mole = 0; prev_vld = 0.
- LFSR step (Galois, right shift): next = (state >> 1) ^ (state[0] ? TAPS : 0). A nonzero state never reaches 0.
- Candidate = state[IDX_W-1:0], taken from the current (pre-step) state.
- seed_load has top priority in every state:
  - state <= (seed == 0) ? all-ones : seed.
  - FSM goes to IDLE and any search in progress is aborted with no mole_valid.
  - A req in the same cycle is dropped.
- IDLE:
  - LFSR steps iff step_en.
  - req = 1 moves to SEARCH: busy = 1 next cycle, try counter = 0.
  - req has no effect in any other state.
- SEARCH (each cycle):
  - The LFSR always steps.
  - Accept when candidate < NUM_MOLES and (!prev_vld or candidate != prev_idx).
  - On accept: register mole_idx = candidate and mole = 1 << candidate; mole_valid = 1 for exactly one cycle (the next cycle); prev_idx = candidate; prev_vld = 1; return to IDLE.
  - On reject: increment try counter. If the counter reaches MAX_TRIES, use the fallback index = prev_vld ? (prev_idx + 1) mod NUM_MOLES : 0, accept it as above, and return to IDLE.
- Latency: the request edge is cycle 0; mole_valid rises at cycle k+1, where k = SEARCH cycles used (1..MAX_TRIES).
- Outputs are registered. mole and mole_idx stay stable between mole_valid pulses. step_en is ignored during SEARCH.
- When NUM_MOLES is a power of two, candidate < NUM_MOLES is always true; only the no-repeat rule can cause a reject.

Optional Feature:
- Macro: MOLE_NO_REPEAT_EN.
- Defined: the no-repeat rule above applies, and prev_idx/prev_vld are implemented.
- Undefined: acceptance is candidate < NUM_MOLES only, and the fallback index is always 0. prev_idx/prev_vld are removed, so repeats are allowed.
- The test plan assumes the macro is defined unless stated otherwise.

Decomposition:
- Package lfsr_pkg holds:
  - the FSM state typedef (IDLE, SEARCH);
  - default TAPS constants per width (3: 3'h6, 4: 4'hC, 5: 5'h14, 8: 8'hB8, 16: 16'hB400);
  - a function lfsr_step(state, taps) returning the next state.
- One sub-module is natural: lfsr_core (WIDTH, TAPS), with ports for load, load value, step, and state. It implements the zero-seed substitution and is reused by other random blocks in the game.

Test Plan:
1. Reset, step_en = 0, NUM_MOLES = 5; pulse req -> candidates from states FF(7), C7(7), DB(3); mole_valid at cycle 4; mole_idx = 3, mole = 5'b01000; state afterwards = D5.
2. After test 1, pulse req -> D5(5) rejected, D2(2) accepted; mole_idx = 2, mole = 5'b00100; mole_valid at cycle 3.
3. seed_load with seed = 0 -> state = FF. seed_load with seed = 0x01, then step_en high for 255 cycles -> state returns to 0x01 and is never 0.
4. MAX_TRIES = 2, reset, req -> FF(7) and C7(7) both rejected -> fallback: mole_idx = 0, mole = 5'b00001, mole_valid at cycle 3.
5. Raise seed_load during SEARCH -> busy falls next cycle, no mole_valid, mole keeps its old value. A req while busy is ignored and causes no extra result.
6. Macro undefined, NUM_MOLES = 8, seed = 0x03 -> first req accepts 3; seed reloaded to 0x03, second req -> mole_idx = 3 again (repeat allowed).

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR types and helpers for the game's random blocks.
package lfsr_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } sel_state_e;

  localparam int unsigned LFSR_MAX_W = 64;

  // Maximal-length Galois feedback masks for the widths used in the game.
  localparam logic [2:0]  TAPS_W3  = 3'h6;
  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [4:0]  TAPS_W5  = 5'h14;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  function automatic logic [LFSR_MAX_W-1:0] default_taps(input int unsigned width);
    case (width)
      3:       return LFSR_MAX_W'(TAPS_W3);
      4:       return LFSR_MAX_W'(TAPS_W4);
      5:       return LFSR_MAX_W'(TAPS_W5);
      8:       return LFSR_MAX_W'(TAPS_W8);
      16:      return LFSR_MAX_W'(TAPS_W16);
      default: return '0;
    endcase
  endfunction

  // Galois right-shift step; callers zero-extend and truncate to their width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] state,
                                                      input logic [LFSR_MAX_W-1:0] taps);
    return (state >> 1) ^ (state[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/lfsr_mole_sel_if.sv
// Control/result bundle between game-control FSM (master) and mole selector (slave).
interface lfsr_mole_sel_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_MOLES = 5
);
  localparam int unsigned IDX_W = (NUM_MOLES > 2) ? $clog2(NUM_MOLES) : 1;

  logic                 seed_load;
  logic [WIDTH-1:0]     seed;
  logic                 step_en;
  logic                 req;
  logic                 busy;
  logic                 mole_valid;
  logic [IDX_W-1:0]     mole_idx;
  logic [NUM_MOLES-1:0] mole;

  modport master (
    output seed_load, seed, step_en, req,
    input  busy, mole_valid, mole_idx, mole
  );

  modport slave (
    input  seed_load, seed, step_en, req,
    output busy, mole_valid, mole_idx, mole
  );
endinterface

// File: rtl/lfsr_core.sv
// Galois LFSR with load and step; a zero load value is replaced by all-ones.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  // Load wins over step so a seed always lands exactly as given.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '1;
    end else if (load) begin
      state <= (load_value == '0) ? '1 : load_value;
    end else if (step) begin
      state <= WIDTH'(lfsr_step(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS)));
    end
  end

endmodule

// File: rtl/lfsr_mole_sel.sv
// Random mole selector: walks the LFSR for an in-range, non-repeating index.
// Build option: MOLE_NO_REPEAT_EN enables the no-repeat rule and prev_idx tracking.
module lfsr_mole_sel
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter int unsigned      NUM_MOLES = 5,
  parameter int unsigned      MAX_TRIES = 16
) (
  input  logic           clk,
  input  logic           reset,
  lfsr_mole_sel_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_MOLES > 2) ? $clog2(NUM_MOLES) : 1;
  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [IDX_W:0]   NUM_MOLES_L = (IDX_W+1)'(NUM_MOLES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_MOLES - 1);
  localparam logic [TRY_W-1:0] TRY_LAST    = TRY_W'(MAX_TRIES - 1);

  sel_state_e           state_q, state_d;
  logic [TRY_W-1:0]     tries_q, tries_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_MOLES-1:0] mole_q, mole_d;

  logic [WIDTH-1:0]     lfsr_state;
  logic [IDX_W-1:0]     cand;
  logic                 in_range;
  logic                 cand_ok;
  logic [IDX_W-1:0]     fallback_idx;
  logic                 take;
  logic [IDX_W-1:0]     sel_idx;
  logic                 unused_state;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (bus.seed_load),
    .load_value (bus.seed),
    .step       ((state_q == SEARCH) || bus.step_en),
    .state      (lfsr_state)
  );

  assign cand         = lfsr_state[IDX_W-1:0];
  assign in_range     = {1'b0, cand} < NUM_MOLES_L;
  assign unused_state = ^lfsr_state;

`ifdef MOLE_NO_REPEAT_EN
  logic [IDX_W-1:0] prev_idx_q;
  logic             prev_vld_q;

  // Remembers the last delivered index so the next pick can avoid it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_idx_q <= '0;
      prev_vld_q <= 1'b0;
    end else if (take) begin
      prev_idx_q <= sel_idx;
      prev_vld_q <= 1'b1;
    end
  end

  assign cand_ok      = in_range && (!prev_vld_q || (cand != prev_idx_q));
  assign fallback_idx = !prev_vld_q             ? '0 :
                        (prev_idx_q == LAST_IDX) ? '0 :
                        prev_idx_q + IDX_W'(1);
`else
  assign cand_ok      = in_range;
  assign fallback_idx = '0;
`endif

  // Next-state and output decode; seed_load aborts everything.
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    take    = 1'b0;
    sel_idx = cand;
    if (bus.seed_load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            state_d = SEARCH;
            tries_d = '0;
          end
        end
        SEARCH: begin
          if (cand_ok) begin
            take    = 1'b1;
            state_d = IDLE;
          end else if (tries_q == TRY_LAST) begin
            take    = 1'b1;
            sel_idx = fallback_idx;
            state_d = IDLE;
          end else begin
            tries_d = tries_q + TRY_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d  = (state_d == SEARCH);
    valid_d = take;
    idx_d   = take ? sel_idx : idx_q;
    mole_d  = take ? (NUM_MOLES'(1) << sel_idx) : mole_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tries_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      mole_q  <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      mole_q  <= mole_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.mole_valid = valid_q;
  assign bus.mole_idx   = idx_q;
  assign bus.mole       = mole_q;

endmodule

// File: tb/tb_lfsr_mole_sel.sv
// Scoreboard bench for lfsr_mole_sel: three configurations, directed requests.
module tb_lfsr_mole_sel;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_mole_sel_if #(.WIDTH(8), .NUM_MOLES(5)) b5 ();
  lfsr_mole_sel_if #(.WIDTH(8), .NUM_MOLES(5)) b2 ();
  lfsr_mole_sel_if #(.WIDTH(8), .NUM_MOLES(8)) b8 ();

  lfsr_mole_sel #(.WIDTH(8), .TAPS(8'hB8), .NUM_MOLES(5), .MAX_TRIES(16)) dut5 (
    .clk(clk), .reset(reset), .bus(b5));
  lfsr_mole_sel #(.WIDTH(8), .TAPS(8'hB8), .NUM_MOLES(5), .MAX_TRIES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2));
  lfsr_mole_sel #(.WIDTH(8), .TAPS(8'hB8), .NUM_MOLES(8), .MAX_TRIES(16)) dut8 (
    .clk(clk), .reset(reset), .bus(b8));

  typedef struct {
    int idx;
    int mole;
    int lat;
  } exp_t;

  exp_t q5[$];
  exp_t q2[$];
  exp_t q8[$];
  int   t0[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q5.size();
      1:       return q2.size();
      default: return q8.size();
    endcase
  endfunction

  task automatic push(input int d, input exp_t e);
    case (d)
      0:       q5.push_back(e);
      1:       q2.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  task automatic pop(input int d, output exp_t e);
    case (d)
      0:       e = q5.pop_front();
      1:       e = q2.pop_front();
      default: e = q8.pop_front();
    endcase
  endtask

  task automatic set_req(input int d, input logic v);
    case (d)
      0:       b5.req = v;
      1:       b2.req = v;
      default: b8.req = v;
    endcase
  endtask

  // Monitor side: every mole_valid pulse must match the oldest expectation.
  task automatic observe(input int d, input logic v, input logic [31:0] idx, input logic [31:0] m);
    exp_t e;
    if (v !== 1'b0) begin
      if (qsize(d) == 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_valid actual idx=%0d required=no pulse", d, idx);
      end else begin
        pop(d, e);
        chk($sformatf("dut%0d_mole_idx", d), idx, 32'(e.idx));
        chk($sformatf("dut%0d_mole", d), m, 32'(e.mole));
        chk($sformatf("dut%0d_latency", d), 32'(cyc - t0[d] + 1), 32'(e.lat));
      end
    end
  endtask

  always @(negedge clk) if (!reset) observe(0, b5.mole_valid, 32'(b5.mole_idx), 32'(b5.mole));
  always @(negedge clk) if (!reset) observe(1, b2.mole_valid, 32'(b2.mole_idx), 32'(b2.mole));
  always @(negedge clk) if (!reset) observe(2, b8.mole_valid, 32'(b8.mole_idx), 32'(b8.mole));

  // Stimulus side: one req pulse, expectation queued before the request edge.
  task automatic request(input int d, input int idx, input int m, input int lat);
    exp_t e;
    @(negedge clk);
    e = '{idx: idx, mole: m, lat: lat};
    push(d, e);
    set_req(d, 1'b1);
    @(posedge clk);
    #1 t0[d] = cyc;
    @(negedge clk);
    set_req(d, 1'b0);
  endtask

  task automatic wait_done(input int d, input int budget);
    exp_t e;
    int   n = 0;
    while (qsize(d) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qsize(d) != 0) begin
      errors++;
      $display("FAIL dut%0d_timeout actual=%0d pending required=0 pending", d, qsize(d));
      while (qsize(d) != 0) pop(d, e);
    end
  endtask

  task automatic load_seed(input int d, input logic [7:0] v);
    @(negedge clk);
    case (d)
      0:       begin b5.seed_load = 1'b1; b5.seed = v; end
      1:       begin b2.seed_load = 1'b1; b2.seed = v; end
      default: begin b8.seed_load = 1'b1; b8.seed = v; end
    endcase
    @(negedge clk);
    b5.seed_load = 1'b0;
    b2.seed_load = 1'b0;
    b8.seed_load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int zero_seen;
    reset = 1'b1;
    b5.seed_load = 1'b0; b5.seed = '0; b5.step_en = 1'b0; b5.req = 1'b0;
    b2.seed_load = 1'b0; b2.seed = '0; b2.step_en = 1'b0; b2.req = 1'b0;
    b8.seed_load = 1'b0; b8.seed = '0; b8.step_en = 1'b0; b8.req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_busy", 32'(b5.busy), 32'd0);
    chk("rst_valid", 32'(b5.mole_valid), 32'd0);
    chk("rst_idx", 32'(b5.mole_idx), 32'd0);
    chk("rst_mole", 32'(b5.mole), 32'd0);
    chk("rst_state", 32'(dut5.u_core.state), 32'hFF);
    chk("rst_mole_dut8", 32'(b8.mole), 32'd0);

    // FF(7) C7(7) DB(3): third candidate wins.
    request(0, 3, 32'b01000, 4);
    wait_done(0, 40);
    chk("t1_state_after", 32'(dut5.u_core.state), 32'hD5);

    // D5(5) out of range, D2(2) accepted.
    request(0, 2, 32'b00100, 3);
    wait_done(0, 40);

    // Zero seed substitution, then one full period of free-run.
    load_seed(0, 8'h00);
    chk("t3_zero_seed", 32'(dut5.u_core.state), 32'hFF);
    load_seed(0, 8'h01);
    chk("t3_seed_01", 32'(dut5.u_core.state), 32'h01);
    b5.step_en = 1'b1;
    zero_seen = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (dut5.u_core.state == 8'h00) zero_seen++;
    end
    b5.step_en = 1'b0;
    chk("t3_never_zero", 32'(zero_seen), 32'd0);
    chk("t3_period", 32'(dut5.u_core.state), 32'h01);
    chk("t3_mole_held", 32'(b5.mole), 32'b00100);

    // Two rejects exhaust MAX_TRIES=2: fallback to index 0.
    request(1, 0, 32'b00001, 3);
    wait_done(1, 40);

    // seed_load mid-search aborts with no result.
    load_seed(0, 8'hFF);
    b5.req = 1'b1;
    @(negedge clk);
    b5.req = 1'b0;
    chk("t5_busy_search", 32'(b5.busy), 32'd1);
    @(negedge clk);
    b5.seed_load = 1'b1;
    b5.seed = 8'hFF;
    @(negedge clk);
    b5.seed_load = 1'b0;
    chk("t5_busy_abort", 32'(b5.busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("t5_mole_kept", 32'(b5.mole), 32'b00100);
    chk("t5_idx_kept", 32'(b5.mole_idx), 32'd2);

    // A req raised while busy must not start a second search.
    request(0, 3, 32'b01000, 4);
    b5.req = 1'b1;
    @(negedge clk);
    b5.req = 1'b0;
    wait_done(0, 40);
    repeat (10) @(negedge clk);
    chk("t5_idle_after", 32'(b5.busy), 32'd0);

    // Power-of-two NUM_MOLES, same seed twice.
    load_seed(2, 8'h03);
    request(2, 3, 32'b00001000, 2);
    wait_done(2, 40);
    load_seed(2, 8'h03);
`ifdef MOLE_NO_REPEAT_EN
    request(2, 1, 32'b00000010, 3);
`else
    request(2, 3, 32'b00001000, 2);
`endif
    wait_done(2, 40);

    repeat (5) @(negedge clk);
    chk("q5_empty", 32'(qsize(0)), 32'd0);
    chk("q2_empty", 32'(qsize(1)), 32'd0);
    chk("q8_empty", 32'(qsize(2)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
